// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_seq_ctrl_pkg: RV32I opcodes, ALU operand / writeback select codes,
// sequencer state encoding and the opcode -> select decoder.
package cpu_seq_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
        CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_ILL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [1:0] op1;
        logic [1:0] op2;
        logic [1:0] wb;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] opc);
        dec_t d;
        d.cls = CL_ILL;
        d.op1 = OP_TYPE_NONE;
        d.op2 = OP_TYPE_NONE;
        d.wb  = WB_SEL_ALU;
        unique case (1'b1)
            opc == OPC_LUI: begin
                d.cls = CL_LUI;
                d.op2 = OP_TYPE_IMM;
            end
            opc == OPC_AUIPC: begin
                d.cls = CL_AUIPC;
                d.op1 = OP_TYPE_PC;
                d.op2 = OP_TYPE_IMM;
            end
            opc == OPC_JAL: begin
                d.cls = CL_JAL;
                d.wb  = WB_SEL_PC4;
            end
            opc == OPC_JALR: begin
                d.cls = CL_JALR;
                d.wb  = WB_SEL_PC4;
            end
            opc == OPC_BRANCH: begin
                d.cls = CL_BRANCH;
                d.op1 = OP_TYPE_REG;
                d.op2 = OP_TYPE_REG;
            end
            opc == OPC_LOAD: begin
                d.cls = CL_LOAD;
                d.op1 = OP_TYPE_REG;
                d.op2 = OP_TYPE_IMM;
                d.wb  = WB_SEL_MEM;
            end
            opc == OPC_STORE: begin
                d.cls = CL_STORE;
                d.op1 = OP_TYPE_REG;
                d.op2 = OP_TYPE_IMM;
            end
            opc == OPC_OPIMM: begin
                d.cls = CL_OPIMM;
                d.op1 = OP_TYPE_REG;
                d.op2 = OP_TYPE_IMM;
            end
            opc == OPC_OP: begin
                d.cls = CL_OP;
                d.op1 = OP_TYPE_REG;
                d.op2 = OP_TYPE_REG;
            end
            default: d.cls = CL_ILL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_perf_counter.sv
// cpu_seq_ctrl_perf_counter: enable-gated wrapping counter of width W.
// Ports: clk, rst (sync, high), en (count strobe), cnt (value).
// With EN=0 no flops are built and cnt is constant zero.
module cpu_seq_ctrl_perf_counter #(
    parameter int W  = 32,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    if (EN) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (en)
                cnt <= cnt + 1'b1;
        end
    end else begin : g_off
        logic unused;
        assign unused = ^{clk, rst, en};
        assign cnt    = '0;
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// with imem/dmem req/ack handshakes, operand/wb selects, PC/RF strobes.
// Ports: clk, rst (sync, high), opcode, br_taken, imem_req/ack,
//   dmem_req/we/ack, ir_we, op1_type, op2_type, wb_sel, pc_sel, pc_we,
//   rf_we, trap (sticky), cycle_cnt, instret_cnt.
// Macro PERF_CNT_EN: builds the cycle/instret counters, else tied to 0.
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic [1:0]       op1_type,
    output logic [1:0]       op2_type,
    output logic [1:0]       wb_sel,
    output logic             pc_sel,
    output logic             pc_we,
    output logic             rf_we,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

`ifdef PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t  state;
    iclass_t cls;
    dec_t    dec;
    logic [TW-1:0] wait_cnt;
    logic    tmo;

    assign dec = decode(opcode);

    // Last allowed wait cycle of the current handshake.
    assign tmo = (MEM_TIMEOUT != 0) &&
                 (wait_cnt == TW'(MEM_TIMEOUT - 1));

    // IR must load in the very cycle the fetch data is valid, so this
    // strobe is the registered request qualified by ack; reset wins.
    assign ir_we = imem_req & imem_ack & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            cls      <= CL_ILL;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            op1_type <= OP_TYPE_NONE;
            op2_type <= OP_TYPE_NONE;
            wb_sel   <= WB_SEL_ALU;
            pc_sel   <= 1'b0;
            pc_we    <= 1'b0;
            rf_we    <= 1'b0;
            trap     <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        // first fetch after reset raises the request
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (tmo) begin
                        imem_req <= 1'b0;
                        trap     <= 1'b1;
                        state    <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec.cls == CL_ILL) begin
                        trap  <= 1'b1;
                        state <= ST_TRAP;
                    end else begin
                        cls      <= dec.cls;
                        op1_type <= dec.op1;
                        op2_type <= dec.op2;
                        wb_sel   <= dec.wb;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_sel <= (cls == CL_JAL) || (cls == CL_JALR) ||
                              ((cls == CL_BRANCH) && br_taken);
                    if (cls == CL_LOAD || cls == CL_STORE) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == CL_STORE);
                        wait_cnt <= '0;
                        state    <= ST_MEM;
                    end else begin
                        pc_we <= 1'b1;
                        rf_we <= (cls != CL_BRANCH);
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc_we    <= 1'b1;
                        rf_we    <= (cls == CL_LOAD);
                        state    <= ST_WB;
                    end else if (tmo) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        trap     <= 1'b1;
                        state    <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    pc_we    <= 1'b0;
                    rf_we    <= 1'b0;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_FETCH;
                end
                ST_TRAP: begin
                    trap <= 1'b1;
                end
                default: begin
                    trap  <= 1'b1;
                    state <= ST_TRAP;
                end
            endcase
        end
    end

    cpu_seq_ctrl_perf_counter #(
        .W  (CNT_W),
        .EN (PERF_EN)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .cnt (cycle_cnt)
    );

    cpu_seq_ctrl_perf_counter #(
        .W  (CNT_W),
        .EN (PERF_EN)
    ) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_WB),
        .cnt (instret_cnt)
    );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: scoreboard bench for cpu_seq_ctrl; expected WB-cycle
// selects/strobes/latency are queued at issue and checked at writeback.
module tb_cpu_seq_ctrl;

    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'b0110011;
    logic          br_taken = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we;
    logic [1:0]    op1_type, op2_type, wb_sel;
    logic          pc_sel, pc_we, rf_we, trap;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    logic          t_rst = 1'b1;
    logic          t_imem_ack = 1'b0;
    logic          t_imem_req, t_dmem_req, t_dmem_we, t_ir_we;
    logic [1:0]    t_op1, t_op2, t_wb;
    logic          t_pc_sel, t_pc_we, t_rf_we, t_trap;
    logic [CW-1:0] t_cyc, t_ret;

    cpu_seq_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .br_taken    (br_taken),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .ir_we       (ir_we),
        .op1_type    (op1_type),
        .op2_type    (op2_type),
        .wb_sel      (wb_sel),
        .pc_sel      (pc_sel),
        .pc_we       (pc_we),
        .rf_we       (rf_we),
        .trap        (trap),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    cpu_seq_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) u_to (
        .clk         (clk),
        .rst         (t_rst),
        .opcode      (7'b0110011),
        .br_taken    (1'b0),
        .imem_req    (t_imem_req),
        .imem_ack    (t_imem_ack),
        .dmem_req    (t_dmem_req),
        .dmem_we     (t_dmem_we),
        .dmem_ack    (1'b0),
        .ir_we       (t_ir_we),
        .op1_type    (t_op1),
        .op2_type    (t_op2),
        .wb_sel      (t_wb),
        .pc_sel      (t_pc_sel),
        .pc_we       (t_pc_we),
        .rf_we       (t_rf_we),
        .trap        (t_trap),
        .cycle_cnt   (t_cyc),
        .instret_cnt (t_ret)
    );

    typedef struct {
        string      name;
        logic [1:0] op1;
        logic [1:0] op2;
        logic [1:0] wb;
        bit         wb_care;
        bit         pc_sel;
        bit         rf_we;
        bit         dwe;
        int         lat;
        int         dcyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cyc = 0;
    int   m_ret = 0;

    always @(posedge clk) m_cyc <= rst ? 0 : m_cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] opc, input logic br,
                                   input int dw);
        exp_t e;
        e.name = "op"; e.op1 = 2'd1; e.op2 = 2'd1; e.wb = 2'd0;
        e.wb_care = 1; e.pc_sel = 0; e.rf_we = 1; e.dwe = 0; e.dcyc = 0;
        case (opc)
            7'b0110111: begin e.name = "lui"; e.op1 = 0; e.op2 = 2; end
            7'b0010111: begin e.name = "auipc"; e.op1 = 3; e.op2 = 2; end
            7'b1101111: begin
                e.name = "jal"; e.op1 = 0; e.op2 = 0; e.wb = 2; e.pc_sel = 1;
            end
            7'b1100111: begin
                e.name = "jalr"; e.op1 = 0; e.op2 = 0; e.wb = 2; e.pc_sel = 1;
            end
            7'b1100011: begin
                e.name = "br"; e.wb_care = 0; e.rf_we = 0; e.pc_sel = br;
            end
            7'b0000011: begin
                e.name = "ld"; e.op2 = 2; e.wb = 1; e.dcyc = dw + 1;
            end
            7'b0100011: begin
                e.name = "st"; e.op2 = 2; e.wb_care = 0; e.rf_we = 0;
                e.dwe = 1; e.dcyc = dw + 1;
            end
            7'b0010011: begin e.name = "opi"; e.op2 = 2; end
            default: e.name = "op";
        endcase
        e.lat = 4 + e.dcyc;
        return e;
    endfunction

    // Called and returns on a negedge.
    task automatic run_instr(input logic [6:0] opc, input logic br,
                             input int iw, input int dw);
        exp_t e;
        int   w, cyc, dcyc;
        logic dwe_seen;
        bit   done;
        sb.push_back(model(opc, br, dw));
        opcode = opc;
        br_taken = br;
        done = 0; cyc = 0; dcyc = 0; dwe_seen = 0;
        w = 0;
        while (!imem_req && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (imem_req) begin
            repeat (iw) @(negedge clk);
            imem_ack = 1'b1;
            #1 chk("ir_we", ir_we, 1);
            cyc = 1;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
                if (dmem_req) begin
                    dcyc++;
                    if (dcyc == 1) dwe_seen = dmem_we;
                    if (dcyc == dw + 1) dmem_ack = 1'b1;
                end
                if (pc_we) done = 1;
            end
        end
        e = sb.pop_front();
        chk({e.name, ".wb_seen"}, done, 1);
        if (done) begin
            m_ret++;
            chk({e.name, ".sel"}, {op1_type, op2_type}, {e.op1, e.op2});
            if (e.wb_care) chk({e.name, ".wb_sel"}, wb_sel, e.wb);
            chk({e.name, ".pc_sel"}, pc_sel, e.pc_sel);
            chk({e.name, ".rf_we"}, rf_we, e.rf_we);
            chk({e.name, ".lat"}, cyc, e.lat);
            chk({e.name, ".dreq_cyc"}, dcyc, e.dcyc);
            if (e.dcyc > 0) chk({e.name, ".dmem_we"}, dwe_seen, e.dwe);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ret = 0;
    endtask

    logic [6:0] opc_tab [9] = '{
        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011
    };

    initial begin
        int bad, w;
        repeat (3) @(negedge clk);
        chk("rst_out", {imem_req, dmem_req, dmem_we, ir_we, op1_type,
            op2_type, wb_sel, pc_sel, pc_we, rf_we, trap}, 0);
        chk("rst_cnt", {cycle_cnt, instret_cnt}, 0);
        chk("to_rst_out", {t_imem_req, t_dmem_req, t_dmem_we, t_ir_we,
            t_op1, t_op2, t_wb, t_pc_sel, t_pc_we, t_rf_we, t_trap,
            t_cyc, t_ret}, 0);
        rst = 1'b0;
        m_ret = 0;

        // ack while no request is outstanding must be ignored
        imem_ack = 1'b1;
        #1 chk("ack_noreq_irwe", ir_we, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ack_noreq_req", imem_req, 1);

        run_instr(7'b0110011, 0, 0, 0);
        run_instr(7'b0000011, 0, 0, 3);
        run_instr(7'b1100011, 1, 0, 0);
        run_instr(7'b1100011, 0, 0, 0);
        run_instr(7'b0100011, 0, 1, 0);
        run_instr(7'b0110111, 0, 0, 0);
        run_instr(7'b0010111, 1, 0, 0);
        run_instr(7'b1101111, 0, 2, 0);
        run_instr(7'b1100111, 0, 0, 0);
        run_instr(7'b0010011, 1, 3, 0);

        for (int i = 0; i < 12; i++) begin
            int unsigned k;
            k = $urandom_range(8, 0);
            run_instr(opc_tab[k], 1'($urandom_range(1, 0)),
                      int'($urandom_range(2, 0)),
                      int'($urandom_range(3, 0)));
        end

        // illegal opcode: sticky trap, no further fetches
        w = 0;
        while (!imem_req && w < 8) begin
            @(negedge clk);
            w++;
        end
        opcode = 7'b1111111;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("trap_set", trap, 1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!trap || imem_req || dmem_req || pc_we || rf_we || ir_we)
                bad++;
        end
        chk("trap_hold", bad, 0);
        do_reset();
        chk("trap_clr", trap, 0);
        run_instr(7'b0110011, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 10; i++) run_instr(7'b0010011, 0, 0, 0);
        @(negedge clk);
`ifdef PERF_CNT_EN
        chk("instret_10", instret_cnt, 10);
        chk("cycle_10", cycle_cnt, CW'(m_cyc));
        for (int i = 0; i < 60; i++) run_instr(7'b0010011, 0, 0, 0);
        @(negedge clk);
        chk("instret_wrap", instret_cnt, CW'(m_ret));
        chk("cycle_wrap", cycle_cnt, CW'(m_cyc));
`else
        chk("perf_tied", {cycle_cnt, instret_cnt}, 0);
`endif

        // timeout instance: reset beats a simultaneous ack
        t_rst = 1'b0;
        w = 0;
        while (!t_imem_req && w < 8) begin
            @(negedge clk);
            w++;
        end
        t_rst = 1'b1;
        t_imem_ack = 1'b1;
        #1 chk("rst_ack_irwe", t_ir_we, 0);
        @(negedge clk);
        chk("rst_ack_req", t_imem_req, 0);
        t_rst = 1'b0;
        t_imem_ack = 1'b0;
        w = 0;
        while (!t_imem_req && w < 8) begin
            @(negedge clk);
            w++;
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!t_imem_req || t_trap) bad++;
            @(negedge clk);
        end
        chk("to_wait", bad, 0);
        chk("to_trap", {t_trap, t_imem_req}, 2'b10);
        repeat (3) @(negedge clk);
        chk("to_sticky", {t_trap, t_imem_req}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
